// File: rtl/sram_axi_bridge_if.sv
// Signal bundle between the CPU's inst/data SRAM-style ports, the bridge and the AXI3 memory side.
// The bridge uses the master view; the CPU core plus memory together use the slave view.
interface sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output araddr, arsize, arvalid,
        input  arready, rdata, rvalid,
        output rready,
        output awaddr, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready, bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  araddr, arsize, arvalid,
        output arready, rdata, rvalid,
        input  rready,
        input  awaddr, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Arbitrates the CPU instruction and data SRAM-style ports onto a single AXI3 master,
// one transaction in flight at a time; data wins ties with instruction fetch.
module sram_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               resetn,
    sram_axi_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_data;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              wr_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done;
    logic              w_done;

    logic grant_data;
    logic grant_inst;
    logic aw_fire;
    logic w_fire;
    logic r_fire;
    logic b_fire;

    assign grant_data = (state == IDLE) && bus.data_req;
    assign grant_inst = (state == IDLE) && bus.inst_req && !bus.data_req;
    assign aw_fire    = (state == W) && !aw_done && bus.awready;
    assign w_fire     = (state == W) && !w_done && bus.wready;
    assign r_fire     = (state == R) && bus.rvalid;
    assign b_fire     = (state == B) && bus.bvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The write leaves W only once both AW and W have been accepted, whichever order they came in.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_data) begin
                    state_nxt = bus.data_wr ? W : AR;
                end else if (grant_inst) begin
                    state_nxt = AR;
                end
            end
            AR: if (bus.arready) state_nxt = R;
            R:  if (bus.rvalid) state_nxt = IDLE;
            W:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = B;
            B:  if (bus.bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_data <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wr_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end else if (grant_data) begin
            owner_data <= 1'b1;
            addr_q     <= bus.data_addr;
            size_q     <= bus.data_size;
            wr_q       <= bus.data_wr;
            wstrb_q    <= bus.data_wstrb;
            wdata_q    <= bus.data_wdata;
        end else if (grant_inst) begin
            owner_data <= 1'b0;
            addr_q     <= bus.inst_addr;
            size_q     <= 2'd2;
            wr_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (b_fire) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end
    end

    assign bus.data_addr_ok = grant_data;
    assign bus.inst_addr_ok = grant_inst;

    // Read data is passed straight through; completion pulses go only to the latched owner.
    assign bus.inst_data_ok = r_fire && !owner_data;
    assign bus.data_data_ok = (r_fire && owner_data) || b_fire;
    assign bus.inst_rdata   = bus.rdata;
    assign bus.data_rdata   = bus.rdata;

    assign bus.araddr  = addr_q;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.arvalid = (state == AR);
    assign bus.rready  = (state == R);

    assign bus.awaddr  = addr_q;
    assign bus.awsize  = {1'b0, size_q};
    assign bus.awvalid = (state == W) && !aw_done;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wvalid  = (state == W) && !w_done && wr_q;
    assign bus.bready  = (state == B);
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: directed scenarios then randomized transactions,
// checked cycle by cycle against a handshake-schedule model and a word-addressed memory model.
module tb_sram_axi_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    sram_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // model_mem follows what the CPU asked for; dut_mem follows what the bridge put on AXI.
    logic [31:0] model_mem [logic [29:0]];
    logic [31:0] dut_mem   [logic [29:0]];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = nw[i*8 +: 8];
        end
        return res;
    endfunction

    task automatic ensureWord(input logic [31:0] a);
        logic [31:0] v;
        if (!model_mem.exists(a[31:2])) begin
            v = $urandom;
            model_mem[a[31:2]] = v;
            dut_mem[a[31:2]]   = v;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        model_mem[a[31:2]] = v;
        dut_mem[a[31:2]]   = v;
    endtask

    function automatic logic [31:0] readDut(input logic [31:0] a);
        if (!dut_mem.exists(a[31:2])) dut_mem[a[31:2]] = $urandom;
        return dut_mem[a[31:2]];
    endfunction

    task automatic idleInputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = '0;
        bus.data_wstrb = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.arready    = 1'b0;
        bus.rdata      = '0;
        bus.rvalid     = 1'b0;
        bus.awready    = 1'b0;
        bus.wready     = 1'b0;
        bus.bvalid     = 1'b0;
    endtask

    // One transaction. Reads: d1 = cycles arvalid waits for arready, d2 = cycles in R before rvalid.
    // Writes: d1 = AW wait, d2 = W wait, d3 = cycles in B before bvalid. Cycle 0 is the request cycle.
    task automatic applyStimulus(input string nm, input bit is_data, input bit wr,
                                 input logic [31:0] addr, input logic [1:0] size,
                                 input logic [3:0] strb, input logic [31:0] wd,
                                 input int d1, input int d2, input int d3,
                                 input bit other_req, input logic [31:0] other_addr,
                                 input bit hold_req, input int abort_at);
        int          m;
        int          last;
        logic [31:0] exp_rd;
        logic [31:0] ar_cap;
        logic [31:0] aw_cap;
        logic [31:0] wd_cap;
        logic [3:0]  ws_cap;
        logic [2:0]  exp_size;
        bit          arv, rr, awv, wv, br, dok, aborted;
        string       p;
        m        = (d1 > d2) ? d1 : d2;
        last     = wr ? (2 + m + d3) : (2 + d1 + d2);
        exp_size = {1'b0, (is_data ? size : 2'd2)};
        ar_cap   = '0;
        aw_cap   = '0;
        wd_cap   = '0;
        ws_cap   = '0;
        aborted  = 1'b0;
        ensureWord(addr);
        exp_rd = model_mem[addr[31:2]];
        for (int c = 0; c <= last && !aborted; c++) begin
            @(negedge clk);
            p = $sformatf("%s@c%0d", nm, c);
            bus.inst_req   = is_data ? other_req : (c == 0 || hold_req);
            bus.inst_addr  = is_data ? other_addr : addr;
            bus.data_req   = is_data && (c == 0 || hold_req);
            bus.data_wr    = wr;
            bus.data_size  = size;
            bus.data_wstrb = strb;
            bus.data_addr  = addr;
            bus.data_wdata = wd;
            if (wr) begin
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                bus.rdata   = $urandom;
                bus.awready = (c == 1 + d1);
                bus.wready  = (c == 1 + d2);
                bus.bvalid  = (c == last);
            end else begin
                bus.arready = (c == 1 + d1);
                bus.rvalid  = (c == last);
                bus.rdata   = (c == last) ? readDut(ar_cap) : $urandom;
                bus.awready = 1'b0;
                bus.wready  = 1'b0;
                bus.bvalid  = 1'b0;
            end
            #1;
            if (c == abort_at) begin
                resetn = 1'b0;
                #1;
                checkOutput({p, " abort arvalid"}, 64'(bus.arvalid), 64'd0);
                checkOutput({p, " abort rready"}, 64'(bus.rready), 64'd0);
                checkOutput({p, " abort awvalid"}, 64'(bus.awvalid), 64'd0);
                checkOutput({p, " abort wvalid"}, 64'(bus.wvalid), 64'd0);
                checkOutput({p, " abort bready"}, 64'(bus.bready), 64'd0);
                checkOutput({p, " abort inst_data_ok"}, 64'(bus.inst_data_ok), 64'd0);
                checkOutput({p, " abort data_data_ok"}, 64'(bus.data_data_ok), 64'd0);
                aborted = 1'b1;
            end else begin
                arv = !wr && c >= 1 && c <= 1 + d1;
                rr  = !wr && c >= 2 + d1;
                awv = wr && c >= 1 && c <= 1 + d1;
                wv  = wr && c >= 1 && c <= 1 + d2;
                br  = wr && c >= 2 + m;
                dok = (c == last);
                checkOutput({p, " data_addr_ok"}, 64'(bus.data_addr_ok), 64'(c == 0 && is_data));
                checkOutput({p, " inst_addr_ok"}, 64'(bus.inst_addr_ok), 64'(c == 0 && !is_data));
                checkOutput({p, " arvalid"}, 64'(bus.arvalid), 64'(arv));
                checkOutput({p, " rready"}, 64'(bus.rready), 64'(rr));
                checkOutput({p, " awvalid"}, 64'(bus.awvalid), 64'(awv));
                checkOutput({p, " wvalid"}, 64'(bus.wvalid), 64'(wv));
                checkOutput({p, " bready"}, 64'(bus.bready), 64'(br));
                checkOutput({p, " inst_data_ok"}, 64'(bus.inst_data_ok), 64'(dok && !is_data));
                checkOutput({p, " data_data_ok"}, 64'(bus.data_data_ok), 64'(dok && is_data));
                if (arv) begin
                    checkOutput({p, " araddr"}, 64'(bus.araddr), 64'(addr));
                    checkOutput({p, " arsize"}, 64'(bus.arsize), 64'(exp_size));
                end
                if (awv) begin
                    checkOutput({p, " awaddr"}, 64'(bus.awaddr), 64'(addr));
                    checkOutput({p, " awsize"}, 64'(bus.awsize), 64'(exp_size));
                end
                if (wv) begin
                    checkOutput({p, " wdata"}, 64'(bus.wdata), 64'(wd));
                    checkOutput({p, " wstrb"}, 64'(bus.wstrb), 64'(strb));
                end
                if (dok && !wr) begin
                    if (is_data) checkOutput({p, " data_rdata"}, 64'(bus.data_rdata), 64'(exp_rd));
                    else         checkOutput({p, " inst_rdata"}, 64'(bus.inst_rdata), 64'(exp_rd));
                end
                if (!wr && c == 1 + d1) ar_cap = bus.araddr;
                if (wr && c == 1 + d1) aw_cap = bus.awaddr;
                if (wr && c == 1 + d2) begin
                    wd_cap = bus.wdata;
                    ws_cap = bus.wstrb;
                end
                if (dok && wr) begin
                    dut_mem[aw_cap[31:2]]  = mergeWord(readDut(aw_cap), wd_cap, ws_cap);
                    model_mem[addr[31:2]]  = mergeWord(model_mem[addr[31:2]], wd, strb);
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            idleInputs();
            @(negedge clk);
            resetn = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] ia;
        int          kind;
        idleInputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset arvalid", 64'(bus.arvalid), 64'd0);
        checkOutput("reset awvalid", 64'(bus.awvalid), 64'd0);
        checkOutput("reset wvalid", 64'(bus.wvalid), 64'd0);
        checkOutput("reset rready", 64'(bus.rready), 64'd0);
        checkOutput("reset bready", 64'(bus.bready), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        preload(32'h1c000000, 32'h02800404);
        $display("[TB] directed scenarios");
        applyStimulus("inst_fast", 1'b0, 1'b0, 32'h1c000000, 2'd2, 4'h0, 32'h0, 0, 0, 0, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("tie_data", 1'b1, 1'b0, 32'h00000100, 2'd2, 4'hf, 32'h0, 0, 0, 0, 1'b1, 32'h1c000004, 1'b0, -1);
        applyStimulus("tie_inst", 1'b0, 1'b0, 32'h1c000004, 2'd2, 4'h0, 32'h0, 0, 0, 0, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("wr_byte", 1'b1, 1'b1, 32'h00000203, 2'd0, 4'h8, 32'hAB000000, 3, 0, 1, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("wr_same", 1'b1, 1'b1, 32'h00000204, 2'd2, 4'hf, 32'h12345678, 2, 2, 0, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("rd_back", 1'b1, 1'b0, 32'h00000200, 2'd2, 4'h0, 32'h0, 0, 0, 0, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("rd_slow", 1'b1, 1'b0, 32'h00000204, 2'd2, 4'h0, 32'h0, 4, 5, 0, 1'b0, 32'h0, 1'b1, -1);
        applyStimulus("rd_abort", 1'b0, 1'b0, 32'h1c000008, 2'd2, 4'h0, 32'h0, 0, 6, 0, 1'b0, 32'h0, 1'b0, 4);
        applyStimulus("rd_after", 1'b0, 1'b0, 32'h1c000008, 2'd2, 4'h0, 32'h0, 0, 1, 0, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("wr_abort", 1'b1, 1'b1, 32'h00000300, 2'd2, 4'hf, 32'hdeadbeef, 0, 0, 4, 1'b0, 32'h0, 1'b0, 3);
        applyStimulus("wr_after", 1'b1, 1'b1, 32'h00000300, 2'd2, 4'hf, 32'hcafef00d, 1, 2, 0, 1'b0, 32'h0, 1'b0, -1);
        applyStimulus("rd_300", 1'b1, 1'b0, 32'h00000300, 2'd2, 4'h0, 32'h0, 1, 0, 0, 1'b0, 32'h0, 1'b0, -1);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a    = 32'h00001000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            ia   = 32'h1c000000 + (32'($urandom_range(0, 7)) << 2);
            case (kind)
                0: applyStimulus($sformatf("rnd%0d_inst", i), 1'b0, 1'b0, ia, 2'd2, 4'h0, 32'h0,
                                 $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0, 32'h0, 1'($urandom), -1);
                1: applyStimulus($sformatf("rnd%0d_drd", i), 1'b1, 1'b0, a, 2'($urandom_range(0, 2)), 4'h0, 32'h0,
                                 $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0, 32'h0, 1'($urandom), -1);
                2: applyStimulus($sformatf("rnd%0d_dwr", i), 1'b1, 1'b1, a, 2'($urandom_range(0, 2)),
                                 4'($urandom_range(1, 15)), $urandom,
                                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                 1'b0, 32'h0, 1'($urandom), -1);
                default: begin
                    applyStimulus($sformatf("rnd%0d_tie", i), 1'b1, 1'($urandom), a, 2'd2,
                                  4'($urandom_range(1, 15)), $urandom,
                                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                  1'b1, ia, 1'b0, -1);
                    applyStimulus($sformatf("rnd%0d_tinst", i), 1'b0, 1'b0, ia, 2'd2, 4'h0, 32'h0,
                                  $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0, 32'h0, 1'b0, -1);
                end
            endcase
        end

        @(negedge clk);
        idleInputs();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
